// File: rtl/ezchips_pkg.sv
// Shared types and default timing constants for the ezchips button-conditioning blocks.
// Also provides a small helper used when sizing the auto-repeat counter.
package ezchips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_REPEAT
  } step_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  localparam int REPEAT_DELAY_DEF    = 5000000;
  localparam int REPEAT_RATE_DEF     = 1000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ezchips_debounce.sv
// Two-flop synchroniser followed by a restartable debounce filter; reusable for any push-button.
// The debounced level only changes after DEBOUNCE_CYCLES consecutive disagreeing samples.
module ezchips_debounce #(
  parameter int DEBOUNCE_CYCLES = ezchips_pkg::DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_raw,
  output logic o_btn_level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_db_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_level  <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
      // Any agreeing sample restarts the window, so short glitches never get through.
      if (r_sync2 == r_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == CNT_LAST) begin
        r_level  <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + CNT_W'(1);
      end
    end
  end

  assign o_btn_level = r_level;

endmodule

// File: rtl/ezchips_step_conditioner.sv
// Button -> count-step conditioner: debounce, rising-edge detect and optional hold auto-repeat.
// Build with EZCHIPS_AUTO_REPEAT_EN defined to enable auto-repeat; otherwise one pulse per press.
module ezchips_step_conditioner
  import ezchips_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE     = REPEAT_RATE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_raw,
  output logic step_pulse,
  output logic btn_level,
  output logic held
);

  // Out-of-range timing makes the counters meaningless, so such an instance never steps.
  localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 2) && (REPEAT_DELAY >= 2) && (REPEAT_RATE >= 2);

  logic        w_btn_level;
  logic        w_rise;
  logic        w_ena;
  logic        r_btn_level_q;
  logic        r_step_pulse;
  step_state_t r_state;

  ezchips_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_btn_raw  (btn_raw),
    .o_btn_level(w_btn_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_level_q <= 1'b0;
    end else begin
      r_btn_level_q <= w_btn_level;
    end
  end

  assign w_rise = w_btn_level & ~r_btn_level_q;
  assign w_ena  = ena & CFG_OK;

`ifdef EZCHIPS_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  logic [RPT_W-1:0] r_rpt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_step_pulse <= 1'b0;
      r_rpt_cnt    <= '0;
    end else begin
      r_step_pulse <= 1'b0;
      if (!w_ena) begin
        r_state   <= ST_IDLE;
        r_rpt_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              r_state      <= ST_PRESS;
              r_step_pulse <= 1'b1;
              r_rpt_cnt    <= '0;
            end
          end
          ST_PRESS: begin
            // Release is tested first so a falling level beats a terminal count.
            if (!w_btn_level) begin
              r_state <= ST_IDLE;
            end else if (r_rpt_cnt == DELAY_LAST) begin
              r_state      <= ST_REPEAT;
              r_step_pulse <= 1'b1;
              r_rpt_cnt    <= '0;
            end else begin
              r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (!w_btn_level) begin
              r_state <= ST_IDLE;
            end else if (r_rpt_cnt == RATE_LAST) begin
              r_step_pulse <= 1'b1;
              r_rpt_cnt    <= '0;
            end else begin
              r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_rpt_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign held = (r_state == ST_REPEAT);
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_step_pulse <= 1'b0;
    end else begin
      r_step_pulse <= 1'b0;
      if (!w_ena) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              r_state      <= ST_PRESS;
              r_step_pulse <= 1'b1;
            end
          end
          ST_PRESS: begin
            if (!w_btn_level) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign held = 1'b0;
`endif

  assign step_pulse = r_step_pulse;
  assign btn_level  = w_btn_level;

endmodule
